// File: rtl/fifo_32x32_ecc.sv
// 32x32 single-clock synchronous FIFO with SECDED Hamming(38,32)+parity protection per word.
// Standard (non-FWFT) read timing; flags are registered from the next-state occupancy.
module fifo_32x32_ecc (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] din,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic        injectsbiterr,
   output logic [31:0] dout,
   output logic        full,
   output logic        almost_full,
   output logic        empty,
   output logic        almost_empty,
   output logic        sbiterr,
   output logic        dbiterr
);

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int ECC_W  = 7;
   localparam int CW_W   = DATA_W + ECC_W;
   localparam int DEPTH  = 1 << ADDR_W;

   // Codeword layout: bit 0 is overall parity, bits 1..38 are Hamming positions 1..38.
   function automatic logic [CW_W-1:0] ecc_encode(input logic [DATA_W-1:0] data);
      logic [CW_W-1:0] cw;
      int d;
      cw = '0;
      d  = 0;
      for (int i = 1; i < CW_W; i++) begin
         if ((i & (i - 1)) != 0) begin
            cw[i] = data[d];
            d++;
         end
      end
      for (int k = 0; k < 6; k++) begin
         for (int i = 1; i < CW_W; i++) begin
            if ((((i >> k) & 1) == 1) && (i != (1 << k))) begin
               cw[1 << k] = cw[1 << k] ^ cw[i];
            end
         end
      end
      cw[0] = ^cw[CW_W-1:1];
      return cw;
   endfunction

   // Returns {dbiterr, sbiterr, data}; a syndrome of 0 with bad parity means the parity bit itself flipped.
   function automatic logic [DATA_W+1:0] ecc_decode(input logic [CW_W-1:0] cw_in);
      logic [CW_W-1:0]   cw;
      logic [5:0]        syn;
      logic              par_err;
      logic [DATA_W-1:0] data;
      int d;
      cw   = cw_in;
      syn  = '0;
      data = '0;
      d    = 0;
      for (int i = 1; i < CW_W; i++) begin
         for (int k = 0; k < 6; k++) begin
            if (((i >> k) & 1) == 1) begin
               syn[k] = syn[k] ^ cw[i];
            end
         end
      end
      par_err = ^cw;
      if (par_err) begin
         for (int i = 1; i < CW_W; i++) begin
            if (int'(syn) == i) begin
               cw[i] = ~cw[i];
            end
         end
      end
      for (int i = 1; i < CW_W; i++) begin
         if ((i & (i - 1)) != 0) begin
            data[d] = cw[i];
            d++;
         end
      end
      return {(!par_err && (syn != '0)), par_err, data};
   endfunction

   logic [CW_W-1:0]   mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   count_next;
   logic              wr_ok;
   logic              rd_ok;
   logic [CW_W-1:0]   wr_word;
   logic [DATA_W+1:0] rd_result;

   always_comb begin
      wr_ok      = wr_en && !full;
      rd_ok      = rd_en && !empty;
      count_next = count;
      if (wr_ok && !rd_ok) begin
         count_next = count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
         count_next = count - 1'b1;
      end
      wr_word = ecc_encode(din);
      if (injectsbiterr) begin
         wr_word[3] = ~wr_word[3];
      end
      rd_result = ecc_decode(mem[rd_ptr]);
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_ok) begin
         mem[wr_ptr] <= wr_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         dout         <= '0;
         sbiterr      <= 1'b0;
         dbiterr      <= 1'b0;
         full         <= 1'b0;
         almost_full  <= 1'b0;
         empty        <= 1'b1;
         almost_empty <= 1'b1;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_ok) begin
            rd_ptr                   <= rd_ptr + 1'b1;
            {dbiterr, sbiterr, dout} <= rd_result;
         end
         count        <= count_next;
         full         <= (count_next == 6'd32);
         almost_full  <= (count_next >= 6'd31);
         empty        <= (count_next == 6'd0);
         almost_empty <= (count_next <= 6'd1);
      end
   end

endmodule

// File: tb/tb_fifo_32x32_ecc.sv
// Self-checking bench for fifo_32x32_ecc: a hand-computed vector table, directed
// multi-cycle sequences and randomized traffic compared against a queue-based model.
module tb_fifo_32x32_ecc;

   logic        clk;
   logic        rst;
   logic [31:0] din;
   logic        wr_en;
   logic        rd_en;
   logic        injectsbiterr;
   logic [31:0] dout;
   logic        full;
   logic        almost_full;
   logic        empty;
   logic        almost_empty;
   logic        sbiterr;
   logic        dbiterr;

   int checks;
   int failures;

   // Reference model: each entry is {injected, data}; injected words must come back corrected.
   logic [32:0] model_q[$];
   logic [31:0] m_dout;
   logic        m_sb;

   typedef struct {
      logic        rst;
      logic        wr;
      logic        rd;
      logic        inj;
      logic [31:0] din;
      logic [31:0] dout;
      logic        sb;
      logic        empty;
      logic        aempty;
      logic        full;
      logic        afull;
   } vec_t;

   vec_t vecs[13];

   fifo_32x32_ecc dut (
      .clk           (clk),
      .rst           (rst),
      .din           (din),
      .wr_en         (wr_en),
      .rd_en         (rd_en),
      .injectsbiterr (injectsbiterr),
      .dout          (dout),
      .full          (full),
      .almost_full   (almost_full),
      .empty         (empty),
      .almost_empty  (almost_empty),
      .sbiterr       (sbiterr),
      .dbiterr       (dbiterr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic w, input logic rd, input logic inj,
                             input logic [31:0] d);
      logic [32:0] e;
      bit wr_ok;
      bit rd_ok;
      if (r) begin
         model_q.delete();
         m_dout = '0;
         m_sb   = 1'b0;
      end else begin
         wr_ok = w && (model_q.size() < 32);
         rd_ok = rd && (model_q.size() > 0);
         if (rd_ok) begin
            e      = model_q.pop_front();
            m_dout = e[31:0];
            m_sb   = e[32];
         end
         if (wr_ok) begin
            model_q.push_back({inj, d});
         end
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, leave time 1 unit past the edge.
   task automatic apply_stimulus(input logic r, input logic w, input logic rd, input logic inj,
                                 input logic [31:0] d);
      rst           = r;
      wr_en         = w;
      rd_en         = rd;
      injectsbiterr = inj;
      din           = d;
      @(posedge clk);
      model_step(r, w, rd, inj, d);
      #1;
   endtask

   task automatic check_model(input string tag);
      check_output({tag, "_dout"},         dout,                m_dout);
      check_output({tag, "_sbiterr"},      32'(sbiterr),        32'(m_sb));
      check_output({tag, "_dbiterr"},      32'(dbiterr),        32'd0);
      check_output({tag, "_empty"},        32'(empty),          32'(model_q.size() == 0));
      check_output({tag, "_almost_empty"}, 32'(almost_empty),   32'(model_q.size() <= 1));
      check_output({tag, "_full"},         32'(full),           32'(model_q.size() == 32));
      check_output({tag, "_almost_full"},  32'(almost_full),    32'(model_q.size() >= 31));
   endtask

   task automatic run_checked(input string tag, input logic r, input logic w, input logic rd,
                              input logic inj, input logic [31:0] d);
      apply_stimulus(r, w, rd, inj, d);
      check_model(tag);
   endtask

   initial begin
      logic [31:0] ctr;
      int fill_level;
      checks   = 0;
      failures = 0;
      m_dout   = '0;
      m_sb     = 1'b0;

      // Hand-computed expectations: {rst,wr,rd,inj,din, dout,sb,empty,aempty,full,afull}
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h5555_5555, 32'hAAAA_AAAA, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h5555_5555, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h5555_5555, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'h5555_5555, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      // Reset held for 10 cycles
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      end
      check_model("reset");

      for (int i = 0; i < 13; i++) begin
         apply_stimulus(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].inj, vecs[i].din);
         check_output($sformatf("vec%0d_dout", i),   dout,                 vecs[i].dout);
         check_output($sformatf("vec%0d_sb", i),     32'(sbiterr),         32'(vecs[i].sb));
         check_output($sformatf("vec%0d_db", i),     32'(dbiterr),         32'd0);
         check_output($sformatf("vec%0d_empty", i),  32'(empty),           32'(vecs[i].empty));
         check_output($sformatf("vec%0d_aempty", i), 32'(almost_empty),    32'(vecs[i].aempty));
         check_output($sformatf("vec%0d_full", i),   32'(full),            32'(vecs[i].full));
         check_output($sformatf("vec%0d_afull", i),  32'(almost_full),     32'(vecs[i].afull));
      end

      // Continuous writes of all-ones, reads join 8 cycles later
      run_checked("cont_rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 8; i++) run_checked("cont_wr", 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
      for (int i = 0; i < 12; i++) begin
         run_checked("cont_rw", 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF);
         check_output("cont_dout_ones", dout, 32'hFFFF_FFFF);
      end

      // Fill 0..31, overflow attempt, drain, then read from empty
      run_checked("fill_rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 32; i++) run_checked("fill_wr", 1'b0, 1'b1, 1'b0, 1'b0, 32'(i));
      check_output("fill_full_direct", 32'(full), 32'd1);
      run_checked("overflow_wr", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0BAD_0BAD);
      for (int i = 0; i < 32; i++) begin
         run_checked("drain_rd", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
         check_output("drain_order", dout, 32'(i));
      end
      run_checked("underflow_rd", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      check_output("underflow_hold", dout, 32'd31);

      // Alternating write/read across pointer wrap
      ctr = 32'h100;
      for (int i = 0; i < 100; i++) begin
         if ((i % 2) == 0) begin
            run_checked("wrap_wr", 1'b0, 1'b1, 1'b0, 1'b0, ctr);
            ctr++;
         end else begin
            run_checked("wrap_rd", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
            check_output("wrap_order", dout, ctr - 32'd1);
         end
      end

      // Reset with 10 words stored discards them
      for (int i = 0; i < 10; i++) run_checked("mid_wr", 1'b0, 1'b1, 1'b0, 1'b0, 32'hC000_0000 + 32'(i));
      run_checked("mid_rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      check_output("mid_rst_empty", 32'(empty), 32'd1);
      run_checked("mid_new_wr", 1'b0, 1'b1, 1'b0, 1'b0, 32'h7777_1234);
      run_checked("mid_new_rd", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      check_output("mid_new_word", dout, 32'h7777_1234);
      run_checked("mid_extra_rd", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

      // Randomized traffic; write bias swings so both full and empty are visited
      for (int i = 0; i < 600; i++) begin
         fill_level = ((i / 100) % 2 == 0) ? 80 : 25;
         run_checked("rand",
                     ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < fill_level) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < 50) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
                     $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
